scroll_sequencer: RTL and testbench
===================================

Name: scroll_sequencer

Overview:
Controller for the four-digit scrolling-text display. It owns the 16-entry message memory, sequences the scroll pointer in run, hold and pause modes, and serves character reads to the digit driver. It also arbitrates a host write port into the message memory, accepting writes only while scrolling is paused. It runs on the display clock, clk_ssd at 5 MHz, and replaces the free-running scroll timer.

Parameters:
TICKS_PER_STEP, 5_000_000, clk cycles per scroll step (1 s at 5 MHz); legal range is 2 and above.
HOLD_STEPS, 2, step periods to dwell after the pointer wraps to 0; 0 disables the dwell.
CNT_W, 23, prescaler width; must satisfy 2^CNT_W >= TICKS_PER_STEP.

Ports:
clk  in  1  display clock; all logic sits on the rising edge.
reset  in  1  synchronous, active-high, already debounced.
pause_btn  in  1  clean button level; a rising edge toggles pause.
dir_btn  in  1  clean button level; a rising edge toggles scroll direction.
step_btn  in  1  clean button level; a rising edge advances one step while paused.
wr_valid  in  1  host write request.
wr_ready  out  1  write accepted when wr_valid and wr_ready are both high on a clk edge.
wr_addr  in  4  message index to write.
wr_data  in  4  character code to write.
relative_addr  in  2  digit index from the digit driver.
char  out  4  mem[(addr+relative_addr) mod 16].
addr  out  4  current scroll pointer.
dir  out  1  0 = scroll left (addr increments), 1 = scroll right (addr decrements).
state  out  2  RUN=0, HOLD=1, PAUSED=2; debug/LED use.
step_tick  out  1  one-cycle pulse at each prescaler terminal count.

Behaviour:
- Reset (synchronous, dominates everything):
  - addr=0, dir=0, state=RUN, prescaler=0, hold_cnt=0.
  - step_tick=0, wr_ready=0, mem[i]=i for i=0..15.
  - Button history registers load the current input levels, so a button held through reset produces no edge.
- Edge detect: a pulse fires when the input is high this cycle and the history register is low. Each button has exactly one register stage of history.
- Prescaler:
  - Counts in RUN and HOLD only. At TICKS_PER_STEP-1 it asserts step_tick for 1 cycle and wraps to 0.
  - In PAUSED it is held at 0 and step_tick=0.
- Advance: addr <= addr+1 when dir=0, or addr-1 when dir=1, modulo 16 (wraps 15->0 and 0->15).
- RUN:
  - On step_tick, advance.
  - If the new addr==0 and HOLD_STEPS>0, go to HOLD with hold_cnt=HOLD_STEPS.
- HOLD:
  - addr is frozen. Each step_tick decrements hold_cnt.
  - The step_tick that takes hold_cnt to 0 returns the block to RUN without advancing; the next advance comes one full period later.
- PAUSED:
  - wr_ready=1 (registered: it rises 1 cycle after entering PAUSED and falls 1 cycle after leaving).
  - A write lands in mem at that edge, so char reflects it the following cycle.
  - A step_btn edge advances once. No HOLD entry happens from PAUSED, even when the pointer reaches 0.
- pause_btn edge:
  - RUN or HOLD -> PAUSED. hold_cnt is cleared and the prescaler is zeroed.
  - PAUSED -> RUN, with the prescaler starting from 0.
- dir_btn edge: toggles dir in any state; it takes effect at the next advance.
- Simultaneous events:
  - pause edge + step_tick in the same cycle: pause wins, no advance.
  - pause edge + step edge while PAUSED: resume wins, step ignored.
  - write + step edge while PAUSED: both take effect.
  - dir edge + advance in the same cycle: the advance uses the old dir.
  - wr_valid while wr_ready=0: ignored, no side effect; the host holds the request.
- char: combinational read with 0 latency; the 4-bit sum wraps (addr=14, rel=3 -> mem[1]).
- Reset asserted mid-write or mid-hold: reset wins, the write is discarded and mem is reinitialized.

Decomposition:
- Shared package led_display_pkg holds:
  - state encoding (RUN/HOLD/PAUSED)
  - MSG_DEPTH=16, ADDR_W=4, CHAR_W=4
  - the reset-time message init function (identity 0..F).
- One natural sub-module: rise_edge_detect (level in, pulse out, history preloaded on reset), instantiated three times.

Test Plan:
All scenarios use TICKS_PER_STEP=4 and HOLD_STEPS=2.
1. Release reset, run 20 cycles -> step_tick every 4th cycle; addr 0->1->2->3->4; char with rel=3 reads 3,4,5,6,7.
2. Run through the wrap -> addr 15->0, state=HOLD, addr stays 0 for 2 step periods (8 cycles), then RUN and addr=1 four cycles later.
3. pause_btn edge in the same cycle as step_tick at addr=5 -> state=PAUSED, addr stays 5, wr_ready=1 next cycle. Then write addr 6 data 0xA -> next cycle, rel=1 gives char=0xA.
4. While PAUSED at addr=0, dir_btn edge then step_btn edge -> addr=15, state stays PAUSED, no HOLD entered.
5. While RUN, wr_valid=1 held -> wr_ready=0 and mem unchanged. Pause -> the write is accepted on the first cycle wr_ready=1.
6. Hold pause_btn high through reset and release reset -> no pause edge, state=RUN. Assert reset in HOLD after writing mem[2]=0xF -> addr=0, state=RUN, mem[2]=2.

Source files
------------

// File: rtl/led_display_pkg.sv
// Shared definitions for the scrolling-text display: sequencer state encoding,
// message memory geometry and the power-on message contents.
package led_display_pkg;

    localparam int MSG_DEPTH = 16;
    localparam int ADDR_W    = 4;
    localparam int CHAR_W    = 4;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HOLD   = 2'd1,
        ST_PAUSED = 2'd2
    } seq_state_t;

    // Reset-time message: entry i holds character code i (0..F).
    function automatic logic [CHAR_W-1:0] msg_init(input int idx);
        return CHAR_W'(idx);
    endfunction

endpackage

// File: rtl/rise_edge_detect.sv
// Rising-edge detector for an already-clean button level.
// One-cycle pulse when the level is high now and was low last cycle.
module rise_edge_detect (
    input  logic clk,
    input  logic level,
    output logic pulse
);

    logic hist;

    // History tracks the level every cycle, including while reset is held,
    // so a button held through reset is already "seen" at release.
    always_ff @(posedge clk) begin
        hist <= level;
    end

    assign pulse = level & ~hist;

endmodule

// File: rtl/scroll_sequencer.sv
// Scroll pointer sequencer for the four-digit display: run/hold/pause modes,
// 16-entry message memory with a host write port open only while paused.
module scroll_sequencer
    import led_display_pkg::*;
#(
    parameter int TICKS_PER_STEP = 5_000_000,
    parameter int HOLD_STEPS     = 2,
    parameter int CNT_W          = 23
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pause_btn,
    input  logic              dir_btn,
    input  logic              step_btn,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [CHAR_W-1:0] wr_data,
    input  logic [1:0]        relative_addr,
    output logic [CHAR_W-1:0] char,
    output logic [ADDR_W-1:0] addr,
    output logic              dir,
    output logic [1:0]        state,
    output logic              step_tick
);

    localparam int HOLD_W = (HOLD_STEPS > 0) ? $clog2(HOLD_STEPS + 1) : 1;

    seq_state_t        state_q, state_n;
    logic [ADDR_W-1:0] addr_q, addr_n, addr_adv, rd_idx;
    logic              dir_q, dir_n;
    logic [CNT_W-1:0]  presc_q, presc_n;
    logic [HOLD_W-1:0] hold_q, hold_n;
    logic              wr_ready_q;
    logic [CHAR_W-1:0] mem [MSG_DEPTH];

    // Buttons packed as {step, dir, pause}
    logic [2:0] btn_lvl, btn_edge;
    logic       pause_e, dir_e, step_e;

    assign btn_lvl = {step_btn, dir_btn, pause_btn};

    rise_edge_detect u_edge [2:0] (
        .clk   (clk),
        .level (btn_lvl),
        .pulse (btn_edge)
    );

    assign pause_e = btn_edge[0];
    assign dir_e   = btn_edge[1];
    assign step_e  = btn_edge[2];

    assign step_tick = (state_q != ST_PAUSED) && (presc_q == CNT_W'(TICKS_PER_STEP - 1));
    // Advance always uses the direction in force before any dir edge this cycle.
    assign addr_adv  = dir_q ? (addr_q - ADDR_W'(1)) : (addr_q + ADDR_W'(1));

    always_comb begin
        state_n = state_q;
        addr_n  = addr_q;
        dir_n   = dir_q ^ dir_e;
        presc_n = presc_q;
        hold_n  = hold_q;
        unique case (state_q)
            ST_RUN, ST_HOLD: begin
                if (pause_e) begin
                    state_n = ST_PAUSED;
                    presc_n = '0;
                    hold_n  = '0;
                end else if (step_tick) begin
                    presc_n = '0;
                    if (state_q == ST_RUN) begin
                        addr_n = addr_adv;
                        if (addr_adv == '0 && HOLD_STEPS > 0) begin
                            state_n = ST_HOLD;
                            hold_n  = HOLD_W'(HOLD_STEPS);
                        end
                    end else begin
                        // Last dwell tick returns to RUN without moving the pointer
                        hold_n = hold_q - HOLD_W'(1);
                        if (hold_q == HOLD_W'(1)) state_n = ST_RUN;
                    end
                end else begin
                    presc_n = presc_q + CNT_W'(1);
                end
            end
            ST_PAUSED: begin
                presc_n = '0;
                if (pause_e)     state_n = ST_RUN;
                else if (step_e) addr_n  = addr_adv;
            end
            default: state_n = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_RUN;
            addr_q     <= '0;
            dir_q      <= 1'b0;
            presc_q    <= '0;
            hold_q     <= '0;
            wr_ready_q <= 1'b0;
            for (int i = 0; i < MSG_DEPTH; i++) mem[i] <= msg_init(i);
        end else begin
            state_q    <= state_n;
            addr_q     <= addr_n;
            dir_q      <= dir_n;
            presc_q    <= presc_n;
            hold_q     <= hold_n;
            wr_ready_q <= (state_q == ST_PAUSED);
            if (wr_valid && wr_ready_q) mem[wr_addr] <= wr_data;
        end
    end

    assign rd_idx   = addr_q + ADDR_W'(relative_addr);
    assign char     = mem[rd_idx];
    assign addr     = addr_q;
    assign dir      = dir_q;
    assign state    = state_q;
    assign wr_ready = wr_ready_q;

endmodule

// File: tb/tb_scroll_sequencer.sv
// Bench for scroll_sequencer: table-driven start-up vectors, hand-written
// corner sequences and a random phase checked against a behavioural model.
module tb_scroll_sequencer;

    localparam int T  = 4;
    localparam int HS = 2;

    logic       clk, reset, pause_btn, dir_btn, step_btn, wr_valid, wr_ready;
    logic [3:0] wr_addr, wr_data, char, addr;
    logic [1:0] relative_addr, state;
    logic       dir, step_tick;

    scroll_sequencer #(.TICKS_PER_STEP(T), .HOLD_STEPS(HS), .CNT_W(3)) dut (
        .clk(clk), .reset(reset), .pause_btn(pause_btn), .dir_btn(dir_btn),
        .step_btn(step_btn), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data), .relative_addr(relative_addr),
        .char(char), .addr(addr), .dir(dir), .state(state), .step_tick(step_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0, n_err = 0, cyc_n = 0;
    bit mchk = 0;

    // Behavioural model: mode 0=run 1=hold 2=paused, phase = cycles into step period
    int m_addr, m_dir, m_mode, m_phase, m_hold, m_wrr;
    int m_mem[16];
    bit prev_p, prev_d, prev_s;

    typedef struct {
        logic [1:0] rel;
        int e_addr, e_state, e_tick, e_char;
    } vec_t;
    vec_t tbl[20];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc_n);
        end
    endtask

    task automatic model_reset();
        m_addr = 0; m_dir = 0; m_mode = 0; m_phase = 0; m_hold = 0; m_wrr = 0;
        for (int i = 0; i < 16; i++) m_mem[i] = i;
    endtask

    task automatic model_step();
        bit pe, de, se, tick;
        int od, nxt;
        if (reset) begin
            model_reset();
        end else begin
            pe = pause_btn && !prev_p;
            de = dir_btn && !prev_d;
            se = step_btn && !prev_s;
            tick = (m_mode != 2) && (m_phase == T - 1);
            if (wr_valid && m_wrr != 0) m_mem[wr_addr] = int'(wr_data);
            m_wrr = (m_mode == 2) ? 1 : 0;
            od = m_dir;
            if (de) m_dir = 1 - m_dir;
            nxt = (m_addr + ((od != 0) ? 15 : 1)) % 16;
            if (m_mode == 2) begin
                m_phase = 0;
                if (pe) m_mode = 0;
                else if (se) m_addr = nxt;
            end else if (pe) begin
                m_mode = 2; m_phase = 0; m_hold = 0;
            end else if (tick) begin
                m_phase = 0;
                if (m_mode == 0) begin
                    m_addr = nxt;
                    if (m_addr == 0 && HS > 0) begin m_mode = 1; m_hold = HS; end
                end else begin
                    m_hold--;
                    if (m_hold == 0) m_mode = 0;
                end
            end else begin
                m_phase++;
            end
        end
        prev_p = pause_btn; prev_d = dir_btn; prev_s = step_btn;
    endtask

    task automatic model_cmp();
        chk("addr", addr, m_addr);
        chk("dir", dir, m_dir);
        chk("state", state, m_mode);
        chk("wr_ready", wr_ready, m_wrr);
        chk("step_tick", step_tick, ((m_mode != 2) && (m_phase == T - 1)) ? 1 : 0);
        chk("char", char, m_mem[(m_addr + int'(relative_addr)) % 16]);
    endtask

    task automatic cyc();
        #2;
        if (mchk) model_cmp();
        @(posedge clk);
        model_step();
        cyc_n++;
        #1;
    endtask

    task automatic press(input int which);
        case (which)
            0: pause_btn = 1'b1;
            1: dir_btn   = 1'b1;
            default: step_btn = 1'b1;
        endcase
        cyc();
        pause_btn = 1'b0; dir_btn = 1'b0; step_btn = 1'b0;
        cyc();
    endtask

    initial begin
        reset = 1'b1; pause_btn = 0; dir_btn = 0; step_btn = 0; wr_valid = 0;
        wr_addr = 0; wr_data = 0; relative_addr = 2'd2;
        for (int i = 0; i < 20; i++) begin
            tbl[i].rel = 2'd3; tbl[i].e_addr = i / 4; tbl[i].e_state = 0;
            tbl[i].e_tick = (i % 4 == 3) ? 1 : 0; tbl[i].e_char = i / 4 + 3;
        end

        // Reset state
        cyc();
        mchk = 1;
        #1;
        chk("rst_addr", addr, 0); chk("rst_state", state, 0); chk("rst_wr_ready", wr_ready, 0);
        chk("rst_tick", step_tick, 0); chk("rst_char", char, 2);
        cyc();
        reset = 1'b0; cyc_n = 0;

        // Start-up scroll, table driven
        for (int i = 0; i < 20; i++) begin
            relative_addr = tbl[i].rel;
            #1;
            chk("t_addr", addr, tbl[i].e_addr); chk("t_state", state, tbl[i].e_state);
            chk("t_tick", step_tick, tbl[i].e_tick); chk("t_char", char, tbl[i].e_char);
            cyc();
        end

        // Wrap into HOLD, dwell two periods, resume
        while (cyc_n < 63) cyc();
        #1; chk("wrap_pre_addr", addr, 15); chk("wrap_pre_tick", step_tick, 1);
        cyc();
        #1; chk("hold_addr", addr, 0); chk("hold_state", state, 1);
        while (cyc_n < 71) cyc();
        #1; chk("hold_end_state", state, 1); chk("hold_end_tick", step_tick, 1);
        cyc();
        #1; chk("hold_exit_state", state, 0); chk("hold_exit_addr", addr, 0);
        while (cyc_n < 76) cyc();
        #1; chk("post_hold_addr", addr, 1);

        // Pause on the same cycle as a step tick, then write while paused
        while (cyc_n < 95) cyc();
        #1; chk("pt_addr", addr, 5); chk("pt_tick", step_tick, 1);
        pause_btn = 1'b1; cyc(); pause_btn = 1'b0;
        #1; chk("pt_state", state, 2); chk("pt_addr_kept", addr, 5); chk("pt_wr_ready_lag", wr_ready, 0);
        cyc();
        wr_valid = 1'b1; wr_addr = 4'd6; wr_data = 4'hA;
        #1; chk("pt_wr_ready", wr_ready, 1);
        cyc();
        wr_valid = 1'b0; relative_addr = 2'd1;
        #1; chk("pt_wr_char", char, 4'hA);

        // Manual steps through 0 while paused, reverse, simultaneous events
        repeat (11) press(2);
        #1; chk("ps_addr0", addr, 0); chk("ps_no_hold", state, 2);
        press(1); press(2);
        #1; chk("ps_rev_addr", addr, 15); chk("ps_rev_state", state, 2); chk("ps_rev_dir", dir, 1);
        dir_btn = 1'b1; step_btn = 1'b1; cyc(); dir_btn = 1'b0; step_btn = 1'b0; cyc();
        #1; chk("dirstep_addr", addr, 14); chk("dirstep_dir", dir, 0);
        wr_valid = 1'b1; wr_addr = 4'd2; wr_data = 4'd9; step_btn = 1'b1;
        cyc();
        wr_valid = 1'b0; step_btn = 1'b0; relative_addr = 2'd3;
        #1; chk("wrstep_addr", addr, 15); chk("wrstep_char", char, 9);
        cyc();
        press(2);
        #1; chk("ps_addr_back0", addr, 0); chk("ps_state", state, 2);

        // Write held during RUN is ignored, accepted once paused
        pause_btn = 1'b1; cyc(); pause_btn = 1'b0;
        #1; chk("res_state", state, 0); chk("res_wr_ready_lag", wr_ready, 1);
        cyc();
        wr_valid = 1'b1; wr_addr = 4'd3; wr_data = 4'hF; relative_addr = 2'd1;
        repeat (8) begin #1; chk("run_wr_ready", wr_ready, 0); cyc(); end
        #1; chk("run_addr", addr, 2);
        pause_btn = 1'b1; cyc(); pause_btn = 1'b0;
        #1; chk("hw_state", state, 2); chk("hw_addr", addr, 2); chk("hw_char_old", char, 3);
        cyc();
        #1; chk("hw_wr_ready", wr_ready, 1);
        cyc();
        wr_valid = 1'b0;
        #1; chk("hw_char_new", char, 4'hF);

        // Reset during HOLD restores the message
        wr_valid = 1'b1; wr_addr = 4'd2; wr_data = 4'hF; cyc(); wr_valid = 1'b0;
        relative_addr = 2'd0;
        #1; chk("m2_char", char, 4'hF);
        press(1); press(2); press(2); press(2);
        #1; chk("to15_addr", addr, 15);
        press(1); press(0);
        repeat (3) cyc();
        #1; chk("rh_state", state, 1); chk("rh_addr", addr, 0);
        reset = 1'b1; cyc();
        #1; chk("rh_rst_addr", addr, 0); chk("rh_rst_state", state, 0); chk("rh_rst_wr_ready", wr_ready, 0);
        reset = 1'b0; relative_addr = 2'd2;
        #1; chk("rh_rst_char", char, 2);

        // Pause held through reset produces no edge
        pause_btn = 1'b1; reset = 1'b1; cyc(); cyc(); reset = 1'b0;
        repeat (3) begin #1; chk("held_state", state, 0); cyc(); end
        pause_btn = 1'b0; cyc();
        #1; chk("held_rel_state", state, 0);

        // Random phase against the model
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 39) == 0) pause_btn = ~pause_btn;
            if ($urandom_range(0, 49) == 0) dir_btn = ~dir_btn;
            if ($urandom_range(0, 5) == 0) step_btn = ~step_btn;
            wr_valid = ($urandom_range(0, 2) == 0);
            wr_addr = 4'($urandom_range(0, 15));
            wr_data = 4'($urandom_range(0, 15));
            relative_addr = 2'($urandom_range(0, 3));
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
